// File: rtl/sha256_msg_padder_pkg.sv
// Shared types, constants and helper functions for the SHA-256 message padder.
package sha256_pkg;

   typedef logic [31:0] word_t;

   localparam word_t PAD_ONE            = 32'h8000_0000;
   localparam int    WORDS_PER_BLOCK    = 16;
   // One word for the 0x80 marker plus two words of 64-bit bit length.
   localparam int    PAD_OVERHEAD_WORDS = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      LATCH = 3'd2,
      EMIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Number of 512-bit blocks needed for an n-word message plus padding.
   function automatic int num_blocks(input int n);
      return (n + PAD_OVERHEAD_WORDS + WORDS_PER_BLOCK - 32'sd1) / WORDS_PER_BLOCK;
   endfunction

   // Word k of the padded stream for k >= n: marker, zero fill or the
   // 64-bit message bit length split over the last two words.
   function automatic word_t pad_word(input logic [15:0] k,
                                      input logic [15:0] n,
                                      input logic [15:0] tw);
      logic [63:0] bit_len;
      bit_len = 64'(n) * 64'd32;
      if (k == n) begin
         pad_word = PAD_ONE;
      end else if (k == tw - 16'd2) begin
         pad_word = bit_len[63:32];
      end else if (k == tw - 16'd1) begin
         pad_word = bit_len[31:0];
      end else begin
         pad_word = 32'h0000_0000;
      end
   endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Reads NUM_OF_WORDS words from a synchronous word memory and streams them,
// followed by SHA-256 padding, as 16-word blocks over a valid/ready port.
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int NUM_OF_WORDS = 20
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] message_addr,
   output logic        busy,
   output logic        done,
   output logic        mem_clk,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   input  logic [31:0] mem_read_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic [3:0]  out_widx,
   output logic        out_first,
   output logic        out_last_block,
   output logic        out_last
);

   localparam logic [15:0] MSG_WORDS        = 16'(NUM_OF_WORDS);
   localparam logic [15:0] TOTAL_WORDS      = 16'(WORDS_PER_BLOCK * num_blocks(NUM_OF_WORDS));
   localparam logic [15:0] LAST_BLOCK_START = TOTAL_WORDS - 16'(WORDS_PER_BLOCK);

   state_t      state_r, state_s;
   logic [15:0] k_r, k_s;
   logic [15:0] rd_addr_r, rd_addr_s;
   word_t       out_word_r, out_word_s;
   logic        out_valid_r, out_valid_s;
   logic        handshake_s;

   assign handshake_s = (state_r == EMIT) && out_valid_r && out_ready;

   // Next-state and next-datapath logic; everything holds unless a state acts on it.
   always_comb begin
      state_s     = state_r;
      k_s         = k_r;
      rd_addr_s   = rd_addr_r;
      out_word_s  = out_word_r;
      out_valid_s = out_valid_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               rd_addr_s = message_addr;
               k_s       = 16'd0;
               state_s   = REQ;
            end else begin
               state_s   = IDLE;
            end
         end
         REQ: begin
            state_s = LATCH;
         end
         LATCH: begin
            out_word_s  = mem_read_data;
            out_valid_s = 1'b1;
            state_s     = EMIT;
         end
         EMIT: begin
            if (handshake_s) begin
               if (k_r == TOTAL_WORDS - 16'd1) begin
                  out_valid_s = 1'b0;
                  state_s     = DONE;
               end else if ((k_r + 16'd1) < MSG_WORDS) begin
                  k_s         = k_r + 16'd1;
                  rd_addr_s   = rd_addr_r + 16'd1;
                  out_valid_s = 1'b0;
                  state_s     = REQ;
               end else begin
                  // Pad words come from logic, so they stream back to back.
                  k_s         = k_r + 16'd1;
                  out_word_s  = pad_word(k_r + 16'd1, MSG_WORDS, TOTAL_WORDS);
                  state_s     = EMIT;
               end
            end else begin
               state_s = EMIT;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s     = IDLE;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         k_r         <= 16'd0;
         rd_addr_r   <= 16'd0;
         out_word_r  <= 32'h0000_0000;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         k_r         <= k_s;
         rd_addr_r   <= rd_addr_s;
         out_word_r  <= out_word_s;
         out_valid_r <= out_valid_s;
      end
   end

   // rd_addr only moves on entry to REQ, so the address is stable elsewhere.
   assign mem_addr       = rd_addr_r;
   assign mem_clk        = clk;
   assign mem_we         = 1'b0;
   assign busy           = (state_r != IDLE);
   assign done           = (state_r == DONE);
   assign out_valid      = out_valid_r;
   assign out_word       = out_word_r;
   assign out_widx       = k_r[3:0];
   assign out_first      = (k_r[3:0] == 4'd0);
   assign out_last_block = (k_r >= LAST_BLOCK_START);
   assign out_last       = (k_r == TOTAL_WORDS - 16'd1);

endmodule
